bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  mm:ss BCD countdown timer; the down-counting counterpart of the up-counting BCD minute/second timer.
//  Loads a BCD preset, counts down one second per qualified tick, flags expiry at 00:00.
//  Sits beside the up-timer in the display/timekeeping path; min/sec outputs drive the same 7-seg decoders.
// PARAMETERS
//  TICK_DIV      1     ticks per decrement (1..255); internal prescaler, TICK_DIV=1 -> every tick
//  MIN_TENS_MAX  9     max minute tens digit accepted on load (preset clamp), range 0..9
// PORTS
//  clk          in   1  single clock; all state changes on posedge clk
//  rst_n        in   1  asynchronous, active-low reset
//  tick         in   1  one-cycle enable pulse (e.g. 1 Hz strobe)
//  load         in   1  load preset_min/preset_sec (clamped); highest priority
//  preset_min   in   8  BCD minutes {tens,ones}
//  preset_sec   in   8  BCD seconds {tens,ones}
//  start        in   1  begin/resume counting
//  stop         in   1  pause counting
//  min          out  8  current BCD minutes
//  sec          out  8  current BCD seconds
//  running      out  1  high in RUN
//  expired      out  1  level, high in EXPIRED
//  done         out  1  one-cycle pulse on the decrement that reaches 00:00
// BEHAVIOUR
//  Reset (rst_n=0, async): min=8'h00, sec=8'h00, state IDLE, prescaler 0, stored preset 00:00, running/expired/done=0.
//  States: IDLE, RUN, PAUSE, EXPIRED. running=(RUN), expired=(EXPIRED); both registered from state.
//  Priority per cycle: load > stop > start > tick.
//  load (any state): next cycle min/sec=clamped preset, preset stored, prescaler=0, state IDLE, done=0.
//   Clamp per digit: ones>9 -> 9; sec tens>5 -> 5; min tens>MIN_TENS_MAX -> MIN_TENS_MAX.
//  start: IDLE/PAUSE -> RUN if value != 00:00, else ignored; prescaler=0. Ignored in RUN/EXPIRED.
//  stop: RUN -> PAUSE, value and prescaler held; tick same cycle dropped. Stop+start same cycle: stop wins.
//  tick in RUN (no load/stop): prescaler++; when prescaler==TICK_DIV-1, prescaler=0 and value decrements.
//   Tick in the same cycle as start is not counted. Ticks in IDLE/PAUSE/EXPIRED ignored.
//  Decrement (BCD borrow chain, all digits updated same edge, value visible next cycle):
//   sec ones 0->9 borrow; sec tens 0->5 borrow; min ones 0->9 borrow; min tens decrements.
//   Never wraps below 00:00: decrement from 00:01 yields 00:00, done=1 for exactly that next cycle, state EXPIRED.
//   01:00 -> 00:59; 10:00 -> 09:59.
//  EXPIRED: value held 00:00; only load exits. start/stop/tick ignored.
//  Latency: load/start/stop -> outputs 1 cycle; tick -> new value 1 cycle; done coincident with 00:00 appearing.
//  rst_n mid-count: immediate return to reset values; done never emitted by reset.
// CONFIGURATION
//  BCD_TIMER_AUTO_RELOAD_EN defined: on the decrement reaching 00:00, value reloads the stored preset in that
//   same edge (00:00 never shown), done pulses, state stays RUN, prescaler=0; EXPIRED unreachable (expired=0).
//   Stored preset 00:00 with start is still ignored.
//  Not defined: behaviour exactly as above (stop in EXPIRED at 00:00).
// STRUCTURE
//  Package bcd_timer_pkg: state typedef (IDLE,RUN,PAUSE,EXPIRED), BCD_NINE=4'd9, BCD_FIVE=4'd5,
//   function bcd_clamp(digit,max).
//  Sub-module bcd_down_digit #(MAX): 4-bit digit, inputs dec/ld/ld_val, outputs value and borrow_out
//   (borrow_out = dec & value==0); four instances chained ones->tens->min ones->min tens.
//  Top holds FSM, prescaler, stored preset, zero detect and done register.
// TESTING
//  1. Reset: rst_n=0 mid-RUN at 12:34 -> min=00, sec=00, running=0, done=0 immediately (async).
//  2. load 01:00, start, 1 tick -> 00:59; 59 more ticks -> 00:00, done=1 one cycle, expired=1, further ticks hold 00:00.
//  3. Borrow chain: load 10:00, start, tick -> 09:59; load 8'hFF:8'h7A -> clamped 99:59 (MIN_TENS_MAX=9).
//  4. Pause: load 00:05, start, 2 ticks -> 00:03; stop+tick same cycle -> PAUSE at 00:03; 5 ticks -> 00:03; start, tick -> 00:02.
//  5. Edge priority: start+stop same cycle from IDLE -> stays IDLE; load during RUN at 00:02 -> IDLE with new preset, done=0.
//  6. TICK_DIV=3: load 00:02, start, 3 ticks -> 00:01. With BCD_TIMER_AUTO_RELOAD_EN: load 00:02, start, 2 ticks -> 00:02, done=1, running=1.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_timer_pkg
// Brief    : Shared state type, BCD digit limits and the per-digit preset clamp.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] max_val);
        return (digit > max_val) ? max_val : digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
//------------------------------------------------------------------------------
// Module   : bcd_down_digit
// Brief    : One BCD down-counting digit; wraps 0 -> MAX and raises borrow_out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_down_digit
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_NINE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] value,
    output logic       borrow_out
);

    logic [3:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 4'd0;
        end else if (ld) begin
            r_value <= ld_val;
        end else if (dec) begin
            r_value <= (r_value == 4'd0) ? MAX : r_value - 4'd1;
        end
    end

    assign value      = r_value;
    assign borrow_out = dec & (r_value == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
//------------------------------------------------------------------------------
// Module   : bcd_countdown_timer
// Brief    : mm:ss BCD countdown timer with prescaler, pause and expiry flag.
//            Define BCD_TIMER_AUTO_RELOAD_EN to reload the stored preset on expiry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [7:0] c_presc_last   = 8'(TICK_DIV - 1);
    localparam logic [3:0] c_min_tens_max = 4'(MIN_TENS_MAX);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_presc, w_presc_nxt;
    logic [7:0] r_pre_min, r_pre_sec;
    logic       r_done, w_done_nxt;
    logic       w_dec, w_reload, w_ld;
    logic [7:0] w_clamp_min, w_clamp_sec, w_ld_min, w_ld_sec;
    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic       w_so_borrow, w_st_borrow, w_mo_borrow, w_unused_borrow;
    logic       w_is_zero, w_is_one;

    assign w_clamp_min = {bcd_clamp(preset_min[7:4], c_min_tens_max), bcd_clamp(preset_min[3:0], BCD_NINE)};
    assign w_clamp_sec = {bcd_clamp(preset_sec[7:4], BCD_FIVE), bcd_clamp(preset_sec[3:0], BCD_NINE)};

    // Reload shares the digit load port; an external load always wins.
    assign w_ld     = load | w_reload;
    assign w_ld_min = load ? w_clamp_min : r_pre_min;
    assign w_ld_sec = load ? w_clamp_sec : r_pre_sec;

    assign w_is_zero = ({min, sec} == 16'h0000);
    assign w_is_one  = ({min, sec} == 16'h0001);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        w_dec       = 1'b0;
        w_reload    = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = 8'd0;
        end else if (stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end
        end else if (start) begin
            if (((r_state == ST_IDLE) || (r_state == ST_PAUSE)) && !w_is_zero) begin
                w_state_nxt = ST_RUN;
                w_presc_nxt = 8'd0;
            end
        end else if (tick && (r_state == ST_RUN)) begin
            if (r_presc == c_presc_last) begin
                w_presc_nxt = 8'd0;
                if (w_is_one) begin
                    w_done_nxt = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    w_reload    = 1'b1;
`else
                    w_dec       = 1'b1;
                    w_state_nxt = ST_EXPIRED;
`endif
                end else begin
                    w_dec = 1'b1;
                end
            end else begin
                w_presc_nxt = r_presc + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= 8'd0;
            r_pre_min <= 8'h00;
            r_pre_sec <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
            if (load) begin
                r_pre_min <= w_clamp_min;
                r_pre_sec <= w_clamp_sec;
            end
        end
    end

    bcd_down_digit #(.MAX(BCD_NINE)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .dec(w_dec), .ld(w_ld), .ld_val(w_ld_sec[3:0]),
        .value(w_so), .borrow_out(w_so_borrow)
    );

    bcd_down_digit #(.MAX(BCD_FIVE)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .dec(w_so_borrow), .ld(w_ld), .ld_val(w_ld_sec[7:4]),
        .value(w_st), .borrow_out(w_st_borrow)
    );

    bcd_down_digit #(.MAX(BCD_NINE)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .dec(w_st_borrow), .ld(w_ld), .ld_val(w_ld_min[3:0]),
        .value(w_mo), .borrow_out(w_mo_borrow)
    );

    // Minute tens never borrows: the value is never decremented below 00:00.
    bcd_down_digit #(.MAX(BCD_NINE)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .dec(w_mo_borrow), .ld(w_ld), .ld_val(w_ld_min[7:4]),
        .value(w_mt), .borrow_out(w_unused_borrow)
    );

    assign min     = {w_mt, w_mo};
    assign sec     = {w_st, w_so};
    assign running = (r_state == ST_RUN);
    assign expired = (r_state == ST_EXPIRED);
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_countdown_timer
// Brief    : Scoreboard bench for two timer instances (TICK_DIV 1 and 3) against a
//            seconds-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_countdown_timer;

    localparam int c_div   [2] = '{1, 3};
    localparam int c_mtmax [2] = '{9, 5};

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       exp;
        logic       dn;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
    logic [7:0] min0, sec0, min1, sec1;
    logic       run0, exp0, done0, run1, exp1, done1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    int m_val [2];
    int m_st  [2];
    int m_pc  [2];
    int m_pre [2];
    bit m_dn  [2];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.TICK_DIV(1), .MIN_TENS_MAX(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .preset_min(preset_min), .preset_sec(preset_sec), .start(start), .stop(stop),
        .min(min0), .sec(sec0), .running(run0), .expired(exp0), .done(done0)
    );

    bcd_countdown_timer #(.TICK_DIV(3), .MIN_TENS_MAX(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .preset_min(preset_min), .preset_sec(preset_sec), .start(start), .stop(stop),
        .min(min1), .sec(sec1), .running(run1), .expired(exp1), .done(done1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t req);
        chk({tag, " min"},     16'(act.mn),  16'(req.mn));
        chk({tag, " sec"},     16'(act.sc),  16'(req.sc));
        chk({tag, " running"}, 16'(act.run), 16'(req.run));
        chk({tag, " expired"}, 16'(act.exp), 16'(req.exp));
        chk({tag, " done"},    16'(act.dn),  16'(req.dn));
    endtask

    function automatic int dclamp(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    // Reference model: value kept as total seconds; states 0 idle, 1 run, 2 pause, 3 expired.
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_st[i] = 0; m_pc[i] = 0; m_pre[i] = 0; m_dn[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ld, input logic [7:0] pm, input logic [7:0] ps,
                              input bit sta, input bit sto, input bit tk);
        int mm, ss;
        m_dn[i] = 1'b0;
        if (ld) begin
            mm = dclamp(int'(pm[7:4]), c_mtmax[i]) * 10 + dclamp(int'(pm[3:0]), 9);
            ss = dclamp(int'(ps[7:4]), 5) * 10 + dclamp(int'(ps[3:0]), 9);
            m_val[i] = mm * 60 + ss;
            m_pre[i] = m_val[i];
            m_pc[i]  = 0;
            m_st[i]  = 0;
        end else if (sto) begin
            if (m_st[i] == 1) m_st[i] = 2;
        end else if (sta) begin
            if ((m_st[i] == 0 || m_st[i] == 2) && m_val[i] != 0) begin
                m_st[i] = 1;
                m_pc[i] = 0;
            end
        end else if (tk && m_st[i] == 1) begin
            m_pc[i]++;
            if (m_pc[i] == c_div[i]) begin
                m_pc[i] = 0;
                m_val[i]--;
                if (m_val[i] == 0) begin
                    m_dn[i] = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    m_val[i] = m_pre[i];
`else
                    m_st[i] = 3;
`endif
                end
            end
        end
    endtask

    function automatic obs_t model_obs(input int i);
        obs_t o;
        int mm, ss;
        mm = m_val[i] / 60;
        ss = m_val[i] % 60;
        o.mn  = {4'(mm / 10), 4'(mm % 10)};
        o.sc  = {4'(ss / 10), 4'(ss % 10)};
        o.run = (m_st[i] == 1);
        o.exp = (m_st[i] == 3);
        o.dn  = m_dn[i];
        return o;
    endfunction

    task automatic step(input bit ld, input logic [7:0] pm, input logic [7:0] ps,
                        input bit sta, input bit sto, input bit tk);
        exp_t e;
        @(posedge clk);
        #2;
        load = ld; preset_min = pm; preset_sec = ps; start = sta; stop = sto; tick = tk;
        model_step(0, ld, pm, ps, sta, sto, tk);
        model_step(1, ld, pm, ps, sta, sto, tk);
        e.a = model_obs(0);
        e.b = model_obs(1);
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] pm, input logic [7:0] ps);
        step(1'b1, pm, ps, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        #1;
        chk({tag, " dut0 min"},  16'(min0),  16'h0000);
        chk({tag, " dut0 sec"},  16'(sec0),  16'h0000);
        chk({tag, " dut0 run"},  16'(run0),  16'h0000);
        chk({tag, " dut0 done"}, 16'(done0), 16'h0000);
        chk({tag, " dut0 exp"},  16'(exp0),  16'h0000);
        chk({tag, " dut1 min"},  16'(min1),  16'h0000);
        chk({tag, " dut1 sec"},  16'(sec1),  16'h0000);
        chk({tag, " dut1 run"},  16'(run1),  16'h0000);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp_obs("dut0", {min0, sec0, run0, exp0, done0}, mon_e.a);
            cmp_obs("dut1", {min1, sec1, run1, exp1, done1}, mon_e.b);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         r_ld, r_sta, r_sto, r_tk;
        logic [7:0] r_pm, r_ps;
        model_reset();
        do_reset("initial reset");

        // Count 01:00 down to expiry, then ticks must hold 00:00.
        do_load(8'h01, 8'h00);
        do_start();
        do_ticks(60);
        do_ticks(5);

        // BCD borrow chain and preset clamp.
        do_load(8'h10, 8'h00);
        do_start();
        do_ticks(1);
        do_load(8'hFF, 8'h7A);
        do_idle(1);

        // Pause: stop with a coincident tick drops the tick.
        do_load(8'h00, 8'h05);
        do_start();
        do_ticks(2);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        do_ticks(5);
        do_start();
        do_ticks(1);

        // Priority: start+stop from IDLE, load while running, start on zero value.
        do_load(8'h00, 8'h03);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        do_start();
        do_ticks(1);
        do_load(8'h00, 8'h07);
        do_idle(1);
        do_load(8'h00, 8'h00);
        do_start();
        do_ticks(2);

        // Asynchronous reset in the middle of a count.
        do_load(8'h12, 8'h34);
        do_start();
        do_ticks(3);
        do_reset("async reset");
        do_idle(2);

        for (int n = 0; n < 3000; n++) begin
            r_ld  = ($urandom_range(0, 99) < 3);
            r_pm  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            r_ps  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            r_sta = ($urandom_range(0, 99) < 10);
            r_sto = ($urandom_range(0, 99) < 4);
            r_tk  = ($urandom_range(0, 99) < 60);
            step(r_ld, r_pm, r_ps, r_sta, r_sto, r_tk);
            if (n == 1500) do_reset("random reset");
        end

        do_idle(2);
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard drained", 16'(sb.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
